acs_traceback: RTL
==================

ACS_TRACEBACK -- requirements
Module: acs_traceback

Interface
REQ-001 SHALL have parameter METRIC_W, default 5, path-metric width in bits; the minimum legal value is 5.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, a request to decode the current bit pairs.
REQ-005 SHALL have ports bit_pair_0..bit_pair_7, input, 2 each, received symbols; bit_pair_0 is earliest in time, [1]=G0 output, [0]=G1 output.
REQ-006 SHALL have port decoded_data, output, 8, the decoded bits; bit n corresponds to bit_pair_n.
REQ-007 SHALL have port done, output, 1, a one-cycle pulse marking decoded_data as new.
REQ-008 SHALL have port refresh, output, 1, a one-cycle pulse requesting the next packet from the upstream buffer.
REQ-009 SHALL have port busy, output, 1, high from the cycle after start is accepted through the done cycle.

Function
REQ-010 SHALL decode a rate-1/2, K=3 code with G0=111 and G1=101 and 4 states; state={s1,s0}, s1=u[n-1], s0=u[n-2]; next state={u,s1}.
REQ-011 SHALL use FSM states IDLE -> ACS (8 cycles) -> TRACE (8 cycles) -> DONE (1 cycle) -> IDLE.
REQ-012 In IDLE, start=1 SHALL latch all 8 pairs into an internal 16-bit register (cycle C0); initialise metric state0=0 and states 1..3 to all-ones; set step to 0.
REQ-013 In ACS cycle C1+n (n=0..7), SHALL compute the Hamming branch metric of latched pair n against each of the 8 transitions, and perform add-compare-select for all 4 states in parallel.
REQ-014 The predecessors of state S SHALL be {S[0],0} and {S[0],1}; the survivor decision bit SHALL be 1 only when {S[0],1} is strictly smaller; ties select {S[0],0}.
REQ-015 Metric addition SHALL saturate at 2^METRIC_W-1 and never wrap.
REQ-016 Survivor storage SHALL be 8 steps x 4 states x 1 bit.
REQ-017 TRACE SHALL start from the state with the minimum final metric (lowest index on a tie) and walk step 7 down to 0, one step per cycle (C9..C16).
REQ-018 At each TRACE step n, SHALL set decoded_data[n]=S[1] and move to predecessor S={S[0],decision[n][S]}.
REQ-019 DONE (C17) SHALL assert done=1 and refresh=1 for exactly one cycle; start-to-done latency is 17 cycles.
REQ-020 decoded_data SHALL hold its value from DONE until it is overwritten during the next TRACE.
REQ-021 start SHALL be ignored in every state except IDLE; the earliest back-to-back accept is C18.
REQ-022 Changes on bit_pair_* after C0 SHALL have no effect on the decode in progress.

Reset
REQ-023 rst SHALL force IDLE at any point, including mid-ACS or mid-TRACE, abandoning the decode without a done or refresh pulse.
REQ-024 On reset: decoded_data=0, done=0, refresh=0, busy=0, metrics/step/survivors=0, min_metric=0.

Configuration
REQ-025 With macro ACS_TRACEBACK_METRIC_OUT_EN defined, SHALL add output min_metric[METRIC_W-1:0], the traceback start metric, updated at DONE and held like decoded_data.
REQ-026 Without ACS_TRACEBACK_METRIC_OUT_EN, the min_metric port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package viterbi_pkg SHALL hold: constraint length 3, NUM_STATES=4, NUM_STEPS=8, generator constants G0=3'b111 and G1=3'b101, and the FSM state encoding.
REQ-028 Branch-metric computation SHALL be a combinational sub-module bm_unit: inputs are a 2-bit received pair and a 2-bit expected pair; output is the 2-bit Hamming distance.

Verification
REQ-029 Clean packet: pairs 7..0 packed = 16'h0D4B, pulse start -> done at C17, decoded_data=8'h0D, refresh=1 at C17, min_metric=0.
REQ-030 Single bit error: 16'h0D5B (pair2=01) -> decoded_data=8'h0D, min_metric=1.
REQ-031 All-zero input: 16'h0000 -> decoded_data=8'h00, min_metric=0, exactly one done and one refresh pulse.
REQ-032 start re-asserted at C5 and C17 -> ignored, busy remains 1, single done pulse; start at C18 -> accepted, done at C35.
REQ-033 rst asserted at C6 -> next cycle busy=0 and decoded_data=0; no done or refresh pulse; a subsequent start with 16'h0D4B decodes to 8'h0D.
REQ-034 Saturation: 16'hFFFF with METRIC_W=5 -> no metric wrap (checked by assertion), done at C17, decoded_data equals the golden model's output.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and trellis helper for the K=3, rate-1/2 Viterbi decoder.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int NUM_STEPS  = 8;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACS   = 2'd1,
    TRACE = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  // Encoder output {G0,G1} on the branch from predecessor {s[0],b} into state s (input bit u = s[1]).
  function automatic logic [1:0] expected_pair(input logic [1:0] s, input logic b);
    logic [2:0] taps;
    taps = {s[1], s[0], b};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/bm_unit.sv
// Branch metric: Hamming distance between a received and an expected 2-bit symbol pair.
module bm_unit (
  input  logic [1:0] rx_pair_i,
  input  logic [1:0] exp_pair_i,
  output logic [1:0] dist_o
);

  logic [1:0] diff;

  assign diff   = rx_pair_i ^ exp_pair_i;
  assign dist_o = {diff[1] & diff[0], diff[1] ^ diff[0]};

endmodule

// File: rtl/acs_traceback.sv
// 8-step Viterbi decoder: add-compare-select over 4 states, then a register-based traceback.
// Optional ACS_TRACEBACK_METRIC_OUT_EN adds the min_metric output.
module acs_traceback
  import viterbi_pkg::*;
#(
  parameter int METRIC_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] bit_pair_0,
  input  logic [1:0] bit_pair_1,
  input  logic [1:0] bit_pair_2,
  input  logic [1:0] bit_pair_3,
  input  logic [1:0] bit_pair_4,
  input  logic [1:0] bit_pair_5,
  input  logic [1:0] bit_pair_6,
  input  logic [1:0] bit_pair_7,
  output logic [7:0] decoded_data,
  output logic       done,
  output logic       refresh,
  output logic       busy
`ifdef ACS_TRACEBACK_METRIC_OUT_EN
  ,
  output logic [METRIC_W-1:0] min_metric
`endif
);

  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  fsm_state_e                  state_q;
  logic [2:0]                  step_q;
  logic [15:0]                 pairs_q;
  logic [METRIC_W-1:0]         metric_q [NUM_STATES];
  logic [NUM_STATES-1:0]       surv_q   [NUM_STEPS];
  logic [1:0]                  trace_q;
  logic [7:0]                  decoded_q;
  logic                        done_q;
  logic                        refresh_q;
  logic                        busy_q;

  logic [1:0]                  cur_pair;
  logic [METRIC_W-1:0]         metric_d [NUM_STATES];
  logic [NUM_STATES-1:0]       dec_d;
  logic [1:0]                  best_idx;
  logic [METRIC_W-1:0]         best_val;
  logic [1:0]                  cur_trace;

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0]          b);
    logic [METRIC_W:0] sum;
    sum = {1'b0, a} + {{(METRIC_W - 1){1'b0}}, b};
    return sum[METRIC_W] ? '1 : sum[METRIC_W-1:0];
  endfunction

  assign cur_pair = pairs_q[{step_q, 1'b0} +: 2];

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam logic [1:0] S  = 2'(s);
    localparam logic [1:0] P0 = {S[0], 1'b0};
    localparam logic [1:0] P1 = {S[0], 1'b1};

    logic [1:0]          bm0;
    logic [1:0]          bm1;
    logic [METRIC_W-1:0] cand0;
    logic [METRIC_W-1:0] cand1;

    bm_unit u_bm0 (
      .rx_pair_i (cur_pair),
      .exp_pair_i(expected_pair(S, 1'b0)),
      .dist_o    (bm0)
    );

    bm_unit u_bm1 (
      .rx_pair_i (cur_pair),
      .exp_pair_i(expected_pair(S, 1'b1)),
      .dist_o    (bm1)
    );

    // Ties go to the even predecessor, so the decision bit needs a strict win.
    assign cand0       = sat_add(metric_q[P0], bm0);
    assign cand1       = sat_add(metric_q[P1], bm1);
    assign dec_d[s]    = (cand1 < cand0);
    assign metric_d[s] = dec_d[s] ? cand1 : cand0;
  end

  always_comb begin
    best_idx = 2'd0;
    best_val = metric_q[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (metric_q[s] < best_val) begin
        best_val = metric_q[s];
        best_idx = 2'(s);
      end
    end
  end

  // Metrics stay frozen during traceback, so the first trace step can pick its start state directly.
  assign cur_trace = (step_q == LAST_STEP) ? best_idx : trace_q;

`ifdef ACS_TRACEBACK_METRIC_OUT_EN
  logic [METRIC_W-1:0] min_metric_q;
  assign min_metric = min_metric_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      pairs_q   <= '0;
      trace_q   <= '0;
      decoded_q <= '0;
      done_q    <= 1'b0;
      refresh_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) metric_q[s] <= '0;
      for (int n = 0; n < NUM_STEPS; n++) surv_q[n] <= '0;
`ifdef ACS_TRACEBACK_METRIC_OUT_EN
      min_metric_q <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      refresh_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pairs_q <= {bit_pair_7, bit_pair_6, bit_pair_5, bit_pair_4,
                        bit_pair_3, bit_pair_2, bit_pair_1, bit_pair_0};
            metric_q[0] <= '0;
            for (int s = 1; s < NUM_STATES; s++) metric_q[s] <= '1;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ACS;
          end
        end
        ACS: begin
          for (int s = 0; s < NUM_STATES; s++) metric_q[s] <= metric_d[s];
          surv_q[step_q] <= dec_d;
          if (step_q == LAST_STEP) begin
            state_q <= TRACE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        TRACE: begin
          decoded_q[step_q] <= cur_trace[1];
          trace_q           <= {cur_trace[0], surv_q[step_q][cur_trace]};
          if (step_q == 3'd0) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            refresh_q <= 1'b1;
`ifdef ACS_TRACEBACK_METRIC_OUT_EN
            min_metric_q <= best_val;
`endif
          end else begin
            step_q <= step_q - 3'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign decoded_data = decoded_q;
  assign done         = done_q;
  assign refresh      = refresh_q;
  assign busy         = busy_q;

endmodule
